// File: rtl/up_down_sweep_sequencer_pkg.sv
// up_down_seq_pkg: shared state encoding and default widths for the sweep sequencer
package up_down_seq_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_SWEEP_W = 4;
  typedef enum logic [2:0] {S_IDLE, S_SEEK, S_UP, S_DWELL_H, S_DOWN, S_DWELL_L} sweep_state_t;
endpackage

// File: rtl/up_down_sweep_sequencer_tick_timer.sv
// seq_tick_timer: loadable down-counter that stops at zero and flags it
module seq_tick_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/up_down_sweep_sequencer.sv
// up_down_sweep_sequencer: triangle-sweep controller for an up/down counter; SWEEP_TIMEOUT_EN adds a stall watchdog
module up_down_sweep_sequencer
  import up_down_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SWEEP_W = DEF_SWEEP_W,
  parameter int DWELL = 2,
  parameter int TMO_CYC = 8
) (
  input  logic               clk,
  input  logic               RST_N,
  input  logic               START,
  input  logic               ABORT,
  input  logic [WIDTH-1:0]   LO,
  input  logic [WIDTH-1:0]   HI,
  input  logic [SWEEP_W-1:0] NSWEEP,
  input  logic [WIDTH-1:0]   VALUE,
  output logic               CNT_EN,
  output logic               CNT_UPDN,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR,
  output logic [SWEEP_W-1:0] SWEEP_CNT
);
  localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DW_LOAD = DW'(DWELL > 0 ? DWELL - 1 : 0);
  sweep_state_t state;
  logic [WIDTH-1:0] lo_q, hi_q;
  logic [SWEEP_W-1:0] nsw_q, nxt_cnt;
  logic updn_q, at_lo, at_hi, seek_move, up_move, dn_move, dwell_zero, timeout;
  assign at_lo = VALUE == lo_q;
  assign at_hi = VALUE == hi_q;
  assign seek_move = state == S_SEEK && !at_lo;
  assign up_move = state == S_UP && !at_hi;
  assign dn_move = state == S_DOWN && !at_lo;
  assign nxt_cnt = SWEEP_CNT + 1'b1;
  assign CNT_EN = !ABORT && (seek_move || up_move || dn_move);
  assign CNT_UPDN = CNT_EN ? (up_move || (seek_move && VALUE < lo_q)) : updn_q;
  assign BUSY = state != S_IDLE;
  seq_tick_timer #(.W(DW)) u_dwell (
    .clk(clk), .rst_n(RST_N),
    .load((state == S_UP && at_hi) || (state == S_DOWN && at_lo)),
    .load_val(DW_LOAD),
    .dec(state == S_DWELL_H || state == S_DWELL_L),
    .zero(dwell_zero)
  );
`ifdef SWEEP_TIMEOUT_EN
  localparam int TW = TMO_CYC > 1 ? $clog2(TMO_CYC) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TMO_CYC > 0 ? TMO_CYC - 1 : 0);
  logic [WIDTH-1:0] value_q;
  logic stall, wd_zero;
  assign stall = CNT_EN && VALUE == value_q;
  seq_tick_timer #(.W(TW)) u_wd (
    .clk(clk), .rst_n(RST_N), .load(!stall), .load_val(TMO_LOAD), .dec(stall), .zero(wd_zero)
  );
  assign timeout = stall && wd_zero;
  always_ff @(posedge clk or negedge RST_N)
    if (!RST_N) value_q <= '0;
    else value_q <= VALUE;
`else
  // watchdog absent: TMO_CYC has no effect, the expression is constant false
  assign timeout = TMO_CYC < 0;
`endif
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      lo_q <= '0;
      hi_q <= '0;
      nsw_q <= '0;
      updn_q <= 1'b0;
      DONE <= 1'b0;
      ERR <= 1'b0;
      SWEEP_CNT <= '0;
    end else begin
      DONE <= 1'b0;
      updn_q <= CNT_UPDN;
      if (ABORT) state <= S_IDLE;
      else if (timeout) begin
        state <= S_IDLE;
        ERR <= 1'b1;
      end else
        case (state)
          S_IDLE: if (START) begin
            lo_q <= LO;
            hi_q <= HI;
            nsw_q <= NSWEEP;
            SWEEP_CNT <= '0;
            ERR <= LO > HI;
            state <= LO > HI ? S_IDLE : S_SEEK;
          end
          S_SEEK: if (at_lo) begin
            DONE <= nsw_q == '0;
            state <= nsw_q == '0 ? S_IDLE : S_UP;
          end
          S_UP: if (at_hi) state <= DWELL > 0 ? S_DWELL_H : S_DOWN;
          S_DWELL_H: if (dwell_zero) state <= S_DOWN;
          S_DOWN: if (at_lo) begin
            SWEEP_CNT <= nxt_cnt;
            DONE <= nxt_cnt == nsw_q;
            state <= nxt_cnt == nsw_q ? S_IDLE : DWELL > 0 ? S_DWELL_L : S_UP;
          end
          S_DWELL_L: if (dwell_zero) state <= S_UP;
          default: state <= S_IDLE;
        endcase
    end
  end
endmodule
